// File: rtl/zjh_shift_reg_n_pkg.sv
// Shared encodings for the universal shift register: mode select values and
// burst-sequencer FSM states.
package zjh_shift_reg_n_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_shift_mode(input logic [1:0] s);
        return (s == MODE_SHR) || (s == MODE_SHL);
    endfunction

endpackage

// File: rtl/zjh_shift_core.sv
// Combinational next-state for the shift register contents: hold, shift
// right (towards MSB), shift left (towards LSB) with optional rotate, or load.
module zjh_shift_core
    import zjh_shift_reg_n_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  mode_e            mode_i,
    input  logic             dsr_i,
    input  logic             dsl_i,
    input  logic             rot_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_next_o
);

    logic shr_in;
    logic shl_in;

    // Rotate replaces the serial input with the bit falling off the other end.
    assign shr_in = rot_i ? q_i[WIDTH-1] : dsr_i;
    assign shl_in = rot_i ? q_i[0]       : dsl_i;

    always_comb begin
        q_next_o = q_i;
        unique case (mode_i)
            MODE_HOLD: q_next_o = q_i;
            MODE_SHR:  q_next_o = {q_i[WIDTH-2:0], shr_in};
            MODE_SHL:  q_next_o = {shl_in, q_i[WIDTH-1:1]};
            MODE_LOAD: q_next_o = d_i;
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/zjh_shift_reg_n.sv
// Universal WIDTH-bit shift register with a counted burst-shift sequencer.
// Holds the Q register, the IDLE/RUN/DONE FSM, the latched direction and counter.
module zjh_shift_reg_n
    import zjh_shift_reg_n_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Rd,
    input  logic             En,
    input  logic [1:0]       S,
    input  logic             Dsr,
    input  logic             Dsl,
    input  logic             Rot,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic [CNT_W-1:0] Cnt,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done
);

    logic [WIDTH-1:0] q_q, q_d;
    state_e           state_q, state_d;
    mode_e            dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            mode_sel;

    zjh_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .q_i      (q_q),
        .mode_i   (mode_sel),
        .dsr_i    (Dsr),
        .dsl_i    (Dsl),
        .rot_i    (Rot),
        .d_i      (D),
        .q_next_o (q_d)
    );

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        mode_sel = MODE_HOLD;
        unique case (state_q)
            ST_IDLE: begin
                // A burst start consumes this edge: latch only, no shift.
                if (Start && is_shift_mode(S)) begin
                    dir_d   = mode_e'(S);
                    cnt_d   = Cnt;
                    state_d = (Cnt != '0) ? ST_RUN : ST_DONE;
                end else begin
                    mode_sel = mode_e'(S);
                end
            end
            ST_RUN: begin
                mode_sel = dir_q;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rd) begin
        if (!Rd) begin
            q_q     <= '0;
            state_q <= ST_IDLE;
            dir_q   <= MODE_HOLD;
            cnt_q   <= '0;
        end else if (En) begin
            q_q     <= q_d;
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status comes straight from the state register, so the two are exclusive.
    assign Q    = q_q;
    assign Busy = (state_q == ST_RUN);
    assign Done = (state_q == ST_DONE);

endmodule
